// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit for the RV32I core.
//
// Sits between the execute stage and the pc_reg / if_id / id_ex stage
// registers. Converts execute-stage redirect and hold requests, plus
// instruction-bus wait, into PC-load, stall and flush controls. A redirect
// that arrives while the pipeline is stalled is parked in pending_addr and
// issued on the first un-stalled cycle. A debug halt handshake freezes the
// pipeline, and two performance counters track stalls and redirects.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous reset, active low
//   jump_en_i       redirect request from ex
//   jump_addr_i     redirect target from ex
//   hold_ex_i       ex multi-cycle operation busy
//   hold_bus_i      instruction bus wait
//   halt_req_i      debug halt request (level)
//   cnt_clr_i       synchronous clear of both counters
//   pc_jump_en_o    pc_reg loads pc_jump_addr_o
//   pc_jump_addr_o  redirect target
//   hold_*_o        stall pc_reg / if_id / id_ex
//   flush_*_o       load a NOP into if_id / id_ex
//   halt_ack_o      core halted (registered)
//   stall_cnt_o     cycles with hold_pc_o=1 outside HALT
//   flush_cnt_o     redirects issued
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_ex_i,
    input  logic             hold_bus_i,
    input  logic             halt_req_i,
    input  logic             cnt_clr_i,
    output logic             pc_jump_en_o,
    output logic [31:0]      pc_jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             halt_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pending_addr_q, pending_addr_d;
    logic               halt_ack_q, halt_ack_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               hold;
    logic               redirect;
    logic [31:0]        redirect_addr;
    logic               stall_all;

    assign hold = hold_ex_i | hold_bus_i;

    // Next-state and combinational control. The three hold outputs always
    // move together, so a single stall_all term drives them; likewise a
    // redirect always flushes both if_id and id_ex.
    always_comb begin
        state_d        = state_q;
        pending_addr_d = pending_addr_q;
        redirect       = 1'b0;
        redirect_addr  = 32'd0;
        stall_all      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (jump_en_i && !hold) begin
                    redirect      = 1'b1;
                    redirect_addr = jump_addr_i;
                end else if (jump_en_i) begin
                    // Redirect cannot be taken while stalled: park it.
                    stall_all      = 1'b1;
                    pending_addr_d = jump_addr_i;
                    state_d        = ST_PEND;
                end else if (hold) begin
                    stall_all = 1'b1;
                end else if (halt_req_i) begin
                    // Pipeline still advances this cycle; freeze from next.
                    state_d = ST_HALT;
                end
            end

            ST_PEND: begin
                // jump_en_i is ignored here: the held ex instruction keeps
                // re-presenting the same jump we already captured.
                if (hold) begin
                    stall_all = 1'b1;
                end else begin
                    redirect      = 1'b1;
                    redirect_addr = pending_addr_q;
                    state_d       = ST_RUN;
                end
            end

            ST_HALT: begin
                stall_all = 1'b1;
                if (!halt_req_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        halt_ack_d = (state_d == ST_HALT);

        // Clear wins over increment in the same cycle.
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(stall_all && (state_q != ST_HALT));
            flush_cnt_d = flush_cnt_q + CNT_W'(redirect);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            pending_addr_q <= 32'd0;
            halt_ack_q     <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pending_addr_q <= pending_addr_d;
            halt_ack_q     <= halt_ack_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    // Combinational outputs are gated by rst so they read 0 for the whole
    // time reset is asserted, independent of the live request inputs.
    assign pc_jump_en_o   = rst & redirect;
    assign pc_jump_addr_o = rst ? redirect_addr : 32'd0;
    assign hold_pc_o      = rst & stall_all;
    assign hold_if_id_o   = rst & stall_all;
    assign hold_id_ex_o   = rst & stall_all;
    assign flush_if_id_o  = rst & redirect;
    assign flush_id_ex_o  = rst & redirect;

    assign halt_ack_o  = halt_ack_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (CNT_W=4 build so the
// counter wrap is reachable quickly). A behavioural model computes the
// expected outputs of every cycle when the stimulus is driven; the entry is
// queued and compared against the DUT at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    localparam int M_RUN  = 0;
    localparam int M_PEND = 1;
    localparam int M_HALT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             hold_ex_i;
    logic             hold_bus_i;
    logic             halt_req_i;
    logic             cnt_clr_i;
    logic             pc_jump_en_o;
    logic [31:0]      pc_jump_addr_o;
    logic             hold_pc_o;
    logic             hold_if_id_o;
    logic             hold_id_ex_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             halt_ack_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .hold_ex_i      (hold_ex_i),
        .hold_bus_i     (hold_bus_i),
        .halt_req_i     (halt_req_i),
        .cnt_clr_i      (cnt_clr_i),
        .pc_jump_en_o   (pc_jump_en_o),
        .pc_jump_addr_o (pc_jump_addr_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .halt_ack_o     (halt_ack_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    typedef struct packed {
        logic             jen;
        logic [31:0]      addr;
        logic             hpc;
        logic             hif;
        logic             hid;
        logic             fif;
        logic             fid;
        logic             ack;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int n_step = 0;

    // model registers (current) and their next values
    int               m_state, n_state;
    logic [31:0]      m_pend,  n_pend;
    logic             m_ack,   n_ack;
    logic [CNT_W-1:0] m_sc,    n_sc;
    logic [CNT_W-1:0] m_fc,    n_fc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (step %0d)", tag, got, want, n_step);
        end
    endtask

    task automatic model(input logic jen, input logic [31:0] ja, input logic hex,
                         input logic hbus, input logic halt, input logic clr,
                         input logic rstn, output exp_t e);
        logic hold;
        e = '0;
        if (!rstn) begin
            m_state = M_RUN; m_pend = 32'd0; m_ack = 1'b0; m_sc = '0; m_fc = '0;
            n_state = M_RUN; n_pend = 32'd0; n_ack = 1'b0; n_sc = '0; n_fc = '0;
            return;
        end
        hold    = hex | hbus;
        e.ack   = m_ack;
        e.sc    = m_sc;
        e.fc    = m_fc;
        n_state = m_state;
        n_pend  = m_pend;
        if (m_state == M_RUN) begin
            if (jen && !hold) begin
                e.jen = 1'b1; e.addr = ja; e.fif = 1'b1; e.fid = 1'b1;
            end else if (jen && hold) begin
                e.hpc = 1'b1; e.hif = 1'b1; e.hid = 1'b1;
                n_pend = ja; n_state = M_PEND;
            end else if (hold) begin
                e.hpc = 1'b1; e.hif = 1'b1; e.hid = 1'b1;
            end else if (halt) begin
                n_state = M_HALT;
            end
        end else if (m_state == M_PEND) begin
            if (hold) begin
                e.hpc = 1'b1; e.hif = 1'b1; e.hid = 1'b1;
            end else begin
                e.jen = 1'b1; e.addr = m_pend; e.fif = 1'b1; e.fid = 1'b1;
                n_state = M_RUN;
            end
        end else begin
            e.hpc = 1'b1; e.hif = 1'b1; e.hid = 1'b1;
            if (!halt) n_state = M_RUN;
        end
        n_ack = (n_state == M_HALT);
        if (clr) begin
            n_sc = '0;
            n_fc = '0;
        end else begin
            n_sc = m_sc + ((e.hpc && m_state != M_HALT) ? 1 : 0);
            n_fc = m_fc + (e.jen ? 1 : 0);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare at negedge,
    // then commit the model at the next rising edge.
    task automatic step(input logic jen, input logic [31:0] ja, input logic hex,
                        input logic hbus, input logic halt, input logic clr,
                        input logic rstn);
        exp_t e;
        jump_en_i   = jen;
        jump_addr_i = ja;
        hold_ex_i   = hex;
        hold_bus_i  = hbus;
        halt_req_i  = halt;
        cnt_clr_i   = clr;
        rst         = rstn;
        model(jen, ja, hex, hbus, halt, clr, rstn, e);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("pc_jump_en",   32'(pc_jump_en_o),  32'(e.jen));
        chk("pc_jump_addr", pc_jump_addr_o,     e.addr);
        chk("hold_pc",      32'(hold_pc_o),     32'(e.hpc));
        chk("hold_if_id",   32'(hold_if_id_o),  32'(e.hif));
        chk("hold_id_ex",   32'(hold_id_ex_o),  32'(e.hid));
        chk("flush_if_id",  32'(flush_if_id_o), 32'(e.fif));
        chk("flush_id_ex",  32'(flush_id_ex_o), 32'(e.fid));
        chk("halt_ack",     32'(halt_ack_o),    32'(e.ack));
        chk("stall_cnt",    32'(stall_cnt_o),   32'(e.sc));
        chk("flush_cnt",    32'(flush_cnt_o),   32'(e.fc));
        $display("step %0d rst=%b j=%b h=%b%b halt=%b clr=%b | pcj=%b addr=%h hold=%b%b%b flush=%b%b ack=%b sc=%0d fc=%0d",
                 n_step, rstn, jen, hex, hbus, halt, clr, pc_jump_en_o, pc_jump_addr_o,
                 hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
                 halt_ack_o, stall_cnt_o, flush_cnt_o);
        n_step++;
        @(posedge clk);
        #1;
        m_state = n_state; m_pend = n_pend; m_ack = n_ack; m_sc = n_sc; m_fc = n_fc;
    endtask

    initial begin
        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'd0; hold_ex_i = 1'b0;
        hold_bus_i = 1'b0; halt_req_i = 1'b0; cnt_clr_i = 1'b0;
        m_state = M_RUN; m_pend = 32'd0; m_ack = 1'b0; m_sc = '0; m_fc = '0;
        @(posedge clk);
        #1;

        // Reset with requests active: outputs must stay 0.
        step(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // Zero-latency redirect to 0x40.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("redir_flush_cnt", 32'(flush_cnt_o), 32'd1);

        // Redirect deferred by 3 cycles of bus wait.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pend_flush_cnt", 32'(flush_cnt_o), 32'd1);
        chk("pend_stall_cnt", 32'(stall_cnt_o), 32'd3);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Five cycles of ex hold.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("hold5_stall_cnt", 32'(stall_cnt_o), 32'd5);
        chk("hold5_flush_cnt", 32'(flush_cnt_o), 32'd0);

        // Halt requested with a redirect in the same cycle.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("halt_flush_cnt", 32'(flush_cnt_o), 32'd1);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall counter wrap and clear-with-stall.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_pre", 32'(stall_cnt_o), 32'd15);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_zero", 32'(stall_cnt_o), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_with_stall", 32'(stall_cnt_o), 32'd0);

        // Reset while PEND holds 0x200: the redirect must be discarded.
        step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("no_stale_redirect", 32'(pc_jump_en_o), 32'd0);
        end

        // Reset while halted drops the acknowledge at once.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
